// File: rtl/ft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft_pkg
// Description : Shared definitions for the factory test-pattern engine.
//               Contains the mode encoding, the default LFSR polynomial and
//               seed, and the binary-to-Gray helper used when FT_GRAY_EN is
//               defined.
// Revision    : 1.0 - initial width-generic release
// ============================================================================
package ft_pkg;

    // Runtime mode select values
    typedef enum logic [1:0] {
        FT_PASS  = 2'd0,
        FT_COUNT = 2'd1,
        FT_LFSR  = 2'd2,
        FT_CHECK = 2'd3
    } ft_mode_e;

    // Defaults are 32 bits wide so any W in 2..32 can take its low bits
    localparam logic [31:0] C_DEF_LFSR_POLY = 32'h0000_00B8;
    localparam logic [31:0] C_DEF_LFSR_SEED = 32'h0000_0001;

    // Binary to reflected-binary Gray code
    function automatic logic [31:0] ft_gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : ft_prescaler
// Description : Programmable tick prescaler. Counts enabled cycles and
//               fires when the count equals the divisor, giving one tick
//               every i_div+1 cycles. i_clr restarts the count from zero
//               and suppresses the tick for that cycle.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_ena           - enable; 0 holds the count
//               i_clr           - synchronous restart (mode switch)
//               i_div           - divisor
//               o_hit           - combinational tick event for this cycle
//               o_tick          - registered one-cycle tick pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ft_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_hit,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_match;

    // Exact compare only: if the divisor drops below the current count the
    // counter runs up to all-ones and wraps naturally before matching again.
    assign w_match = (r_cnt == i_div);
    assign o_hit   = i_ena && !i_clr && w_match;
    assign o_tick  = r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            // Tick is not held while disabled: it drops to zero.
            r_tick <= o_hit;
            if (i_ena) begin
                if (i_clr || w_match) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/factory_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : factory_test_gen
// Description : Width-generic bring-up / test-pattern engine. Modes:
//               PASS (din -> dout), COUNT (prescaled counter), LFSR
//               (Galois pattern) and CHECK (bidir loopback checker with a
//               sticky error flag and saturating error counter).
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               ena       - design enable, 0 freezes all state
//               mode      - 0 PASS, 1 COUNT, 2 LFSR, 3 CHECK
//               div       - prescaler divisor (tick every div+1 cycles)
//               clr       - synchronous clear of err / err_cnt
//               din, bin  - dedicated input, bidir input path
//               dout,bout - dedicated output, bidir output path
//               boe       - bidir output enable (combinational decode)
//               tick      - one-cycle prescaler pulse
//               err       - sticky CHECK mismatch flag
//               err_cnt   - saturating CHECK mismatch count
// Options     : FT_GRAY_EN - COUNT drives Gray(count) and CHECK compares
//               bin against Gray(count); undefined gives plain binary.
// Revision    : 1.0 - parametrised successor of the fixed 8-bit top
// ============================================================================
module factory_test_gen
    import ft_pkg::*;
#(
    parameter int             W         = 8,
    parameter int             DIV_W     = 8,
    parameter int             ERR_W     = 8,
    parameter logic [W-1:0]   LFSR_POLY = W'(C_DEF_LFSR_POLY),
    parameter logic [W-1:0]   LFSR_SEED = W'(C_DEF_LFSR_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    input  logic [W-1:0]     din,
    input  logic [W-1:0]     bin,
    output logic [W-1:0]     dout,
    output logic [W-1:0]     bout,
    output logic [W-1:0]     boe,
    output logic             tick,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [1:0]       r_mode_q;
    logic [W-1:0]     r_count;
    logic [W-1:0]     r_lfsr;
    logic [W-1:0]     r_dout;
    logic [W-1:0]     r_bout;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_switch;
    logic             w_hit;
    logic [W-1:0]     w_count_pat;
    logic [W-1:0]     w_lfsr_step;
    logic [W-1:0]     w_lfsr_next;
    logic             w_mismatch;

    assign w_switch = (mode != r_mode_q);

    ft_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_ena  (ena),
        .i_clr  (w_switch),
        .i_div  (div),
        .o_hit  (w_hit),
        .o_tick (tick)
    );

`ifdef FT_GRAY_EN
    assign w_count_pat = W'(ft_gray(32'(r_count)));
`else
    assign w_count_pat = r_count;
`endif

    // Galois step; a zero state would lock up, so it is replaced by the seed
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
    assign w_lfsr_next = (w_lfsr_step == '0) ? LFSR_SEED : w_lfsr_step;

    assign w_mismatch = w_hit && (r_mode_q == FT_CHECK) && (bin != w_count_pat);

    assign boe = (ena && ((r_mode_q == FT_COUNT) || (r_mode_q == FT_LFSR))) ? '1 : '0;

    assign dout    = r_dout;
    assign bout    = r_bout;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q  <= FT_PASS;
            r_count   <= '0;
            r_lfsr    <= LFSR_SEED;
            r_dout    <= '0;
            r_bout    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (ena) begin
            // Pattern state
            if (w_switch) begin
                r_mode_q <= mode;
                r_count  <= '0;
                r_lfsr   <= LFSR_SEED;
            end else if (w_hit) begin
                case (r_mode_q)
                    FT_COUNT, FT_CHECK: r_count <= r_count + W'(1);
                    FT_LFSR:            r_lfsr  <= w_lfsr_next;
                    default:            ;
                endcase
            end

            // Outputs follow the state register, so a new pattern value
            // appears the cycle after the tick that produced it.
            case (r_mode_q)
                FT_PASS: begin
                    r_dout <= din;
                    r_bout <= '0;
                end
                FT_COUNT: begin
                    r_dout <= w_count_pat;
                    r_bout <= w_count_pat;
                end
                FT_LFSR: begin
                    r_dout <= r_lfsr;
                    r_bout <= ~r_lfsr;
                end
                default: begin
                    r_dout <= r_count;
                    r_bout <= '0;
                end
            endcase

            // Clear has priority; a coincident mismatch is dropped entirely
            if (clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_factory_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_factory_test_gen
// Description : Self-checking bench for factory_test_gen (default build,
//               W=8). A cycle-level reference model tracks mode, prescaler,
//               counter value, position in the LFSR sequence and error
//               state; directed sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_factory_test_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] div;
    logic       clr;
    logic [7:0] din;
    logic [7:0] bin;
    logic [7:0] dout;
    logic [7:0] bout;
    logic [7:0] boe;
    logic       tick;
    logic       err;
    logic [7:0] err_cnt;

    factory_test_gen dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .mode    (mode),
        .div     (div),
        .clr     (clr),
        .din     (din),
        .bin     (bin),
        .dout    (dout),
        .bout    (bout),
        .boe     (boe),
        .tick    (tick),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode, m_presc, m_count, m_idx, m_err, m_errcnt, m_dout, m_bout, m_tick;
    int lfsr_tab[255];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic [7:0] exp_boe;
    } vec_t;
    vec_t pass_tab[5];
    int   lfsr_exp[4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_presc = 0; m_count = 0; m_idx = 0;
        m_err = 0; m_errcnt = 0; m_dout = 0; m_bout = 0; m_tick = 0;
    endtask

    task automatic model_step();
        bit sw;
        bit hit;
        if (!ena) begin
            m_tick = 0;
            return;
        end
        sw  = (int'(mode) != m_mode);
        hit = !sw && (m_presc == int'(div));
        case (m_mode)
            0:       begin m_dout = int'(din); m_bout = 0; end
            1:       begin m_dout = m_count; m_bout = m_count; end
            2:       begin m_dout = lfsr_tab[m_idx]; m_bout = 255 - lfsr_tab[m_idx]; end
            default: begin m_dout = m_count; m_bout = 0; end
        endcase
        if (clr) begin
            m_err = 0; m_errcnt = 0;
        end else if (hit && m_mode == 3 && int'(bin) != m_count) begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
        end
        if (sw) begin
            m_mode = int'(mode); m_count = 0; m_idx = 0; m_presc = 0;
        end else begin
            m_presc = hit ? 0 : (m_presc + 1) % 256;
            if (hit && (m_mode == 1 || m_mode == 3)) m_count = (m_count + 1) % 256;
            if (hit && m_mode == 2) m_idx = (m_idx + 1) % 255;
        end
        m_tick = hit;
    endtask

    task automatic compare_all();
        chk("dout",    int'(dout),    m_dout);
        chk("bout",    int'(bout),    m_bout);
        chk("boe",     int'(boe),     (ena && (m_mode == 1 || m_mode == 2)) ? 255 : 0);
        chk("tick",    int'(tick),    m_tick);
        chk("err",     int'(err),     m_err);
        chk("err_cnt", int'(err_cnt), m_errcnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int v;
        int ticks;
        int last;
        int prev;
        int seen;
        int bad;
        int c;
        logic [7:0] hold_dout;
        logic [7:0] hold_bout;

        // Sequence of the 8-bit Galois LFSR, poly 0xB8, seed 1
        v = 1;
        for (int i = 0; i < 255; i++) begin
            lfsr_tab[i] = v;
            v = (v >> 1) ^ (((v & 1) != 0) ? 'hB8 : 0);
            if (v == 0) v = 1;
        end
        pass_tab[0] = '{8'hA5, 8'hA5, 8'h00};
        pass_tab[1] = '{8'h5A, 8'h5A, 8'h00};
        pass_tab[2] = '{8'h00, 8'h00, 8'h00};
        pass_tab[3] = '{8'hFF, 8'hFF, 8'h00};
        pass_tab[4] = '{8'h3C, 8'h3C, 8'h00};
        lfsr_exp[0] = 'h01; lfsr_exp[1] = 'hB8; lfsr_exp[2] = 'h5C; lfsr_exp[3] = 'h2E;

        rst = 1'b1; ena = 1'b0; mode = 2'd0; div = 8'd0; clr = 1'b0; din = 8'd0; bin = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;

        // PASS: 1-cycle latency, bidir disabled
        for (int i = 0; i < 5; i++) begin
            din = pass_tab[i].din;
            step();
            chk("pass_dout", int'(dout), int'(pass_tab[i].exp_dout));
            chk("pass_boe",  int'(boe),  int'(pass_tab[i].exp_boe));
        end

        // COUNT, div=2: tick every 3 cycles, dout 0,1,2 at the ticks
        mode = 2'd1; div = 8'd2;
        step();
        chk("switch_tick", int'(tick), 0);
        ticks = 0; last = -1;
        for (int k = 0; k < 40 && ticks < 3; k++) begin
            step();
            if (tick) begin
                chk("count_tick_dout", int'(dout), ticks);
                if (last >= 0) chk("count_tick_gap", k - last, 3);
                last = k;
                ticks++;
            end
        end
        chk("count_ticks_seen", ticks, 3);
        chk("count_boe", int'(boe), 255);

        // COUNT wrap 0xFF -> 0x00
        div = 8'd0;
        prev = -1; seen = 0;
        for (int k = 0; k < 600 && seen == 0; k++) begin
            step();
            if (tick) begin
                if (prev == 255) begin
                    chk("count_wrap", int'(dout), 0);
                    seen = 1;
                end
                prev = int'(dout);
            end
        end
        chk("count_wrap_seen", seen, 1);

        // LFSR, div=0: known first values, no zero, period 255
        mode = 2'd2;
        step();
        ticks = 0; bad = 0;
        for (int k = 0; k < 300 && ticks < 256; k++) begin
            step();
            if (tick) begin
                if (ticks < 4) chk("lfsr_seq", int'(dout), lfsr_exp[ticks]);
                if (dout == 8'h00) bad++;
                if (ticks > 0 && ticks < 255 && dout == 8'h01) bad++;
                if (ticks == 255) chk("lfsr_period", int'(dout), 1);
                ticks++;
            end
        end
        chk("lfsr_no_zero_or_early_repeat", bad, 0);
        chk("lfsr_ticks_seen", ticks, 256);

        // CHECK with loopback, then a forced mismatch at count 5
        mode = 2'd3; bin = 8'd0;
        step();
        c = 0;
        while (m_count != 5 && c < 50) begin
            bin = 8'(m_count);
            step();
            c++;
        end
        chk("check_reach5", m_count, 5);
        chk("check_err_clean", int'(err), 0);
        bin = 8'h00;
        step();
        chk("check_err_set", int'(err), 1);
        chk("check_err_cnt1", int'(err_cnt), 1);

        // 300 mismatches saturate the counter
        for (int k = 0; k < 300; k++) begin
            bin = ~8'(m_count);
            step();
        end
        chk("check_sat", int'(err_cnt), 255);
        chk("check_sat_err", int'(err), 1);

        // clr wins over a coincident mismatch
        bin = ~8'(m_count); clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_err", int'(err), 0);
        chk("clr_err_cnt", int'(err_cnt), 0);
        bin = 8'(m_count);
        step();
        chk("clr_after_match", int'(err), 0);

        // Switch COUNT -> LFSR at count 0x10, then freeze for 5 cycles
        mode = 2'd1;
        step();
        c = 0;
        while (m_count != 16 && c < 50) begin
            step();
            c++;
        end
        chk("sw_reach10", m_count, 16);
        mode = 2'd2;
        step();
        chk("sw_cycle_tick", int'(tick), 0);
        hold_dout = dout; hold_bout = bout;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("freeze_boe", int'(boe), 0);
            chk("freeze_tick", int'(tick), 0);
            chk("freeze_dout", int'(dout), int'(hold_dout));
            chk("freeze_bout", int'(bout), int'(hold_bout));
        end
        ena = 1'b1;
        step();
        chk("resume_tick", int'(tick), 1);
        chk("resume_lfsr", int'(dout), 1);

        // Randomised run against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) div = 8'($urandom_range(3));
            ena = ($urandom_range(7) != 0);
            clr = ($urandom_range(31) == 0);
            din = 8'($urandom);
            bin = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(m_count);
            step();
        end

        // Asynchronous reset in the middle of COUNT at count 0x37
        ena = 1'b1; clr = 1'b0; mode = 2'd1; div = 8'd0;
        c = 0;
        while (m_dout != 'h37 && c < 600) begin
            step();
            c++;
        end
        chk("rst_reach37", int'(dout), 'h37);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_dout",    int'(dout),    0);
        chk("rst_bout",    int'(bout),    0);
        chk("rst_boe",     int'(boe),     0);
        chk("rst_tick",    int'(tick),    0);
        chk("rst_err",     int'(err),     0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mode = 2'd0; din = 8'h77;
        step();
        chk("post_rst_pass", int'(dout), 'h77);
        chk("post_rst_boe",  int'(boe),  0);
        mode = 2'd2;
        step();
        step();
        chk("post_rst_lfsr", int'(dout), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
